// File: rtl/div_pkg.sv
// Shared definitions for the divider sign/sequencing front end.
package div_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_fe_state_t;

endpackage

// File: rtl/cond_negate.sv
// Combinational conditional two's-complement negate; INT_MIN maps to itself.
module cond_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/div_sign_frontend.sv
// Sign handling and sequencing in front of the unsigned divide core;
// resolves divide-by-zero and signed overflow without starting the core.
module div_sign_frontend
    import div_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flush_ex,
    input  logic [2:0]        funct3,
    input  logic [XLEN_P-1:0] a,
    input  logic [XLEN_P-1:0] b,
    output logic              busy,
    output logic              out_valid,
    output logic [XLEN_P-1:0] result,
    output logic              core_valid,
    output logic [XLEN_P-1:0] core_a,
    output logic [XLEN_P-1:0] core_b,
    output logic [2:0]        core_funct3,
    input  logic [XLEN_P-1:0] core_y,
    input  logic [XLEN_P-1:0] core_rem,
    input  logic              core_done
);

    div_fe_state_t     state_r;
    logic              rem_sel_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic              out_valid_r;
    logic              core_valid_r;
    logic [XLEN_P-1:0] result_r;
    logic [XLEN_P-1:0] core_a_r;
    logic [XLEN_P-1:0] core_b_r;
    logic [XLEN_P-1:0] y_r;
    logic [XLEN_P-1:0] rem_r;

    logic              signed_s;
    logic              neg_a_s;
    logic              neg_b_s;
    logic              div_zero_s;
    logic              overflow_s;
    logic [XLEN_P-1:0] a_mag_s;
    logic [XLEN_P-1:0] b_mag_s;
    logic [XLEN_P-1:0] q_fix_s;
    logic [XLEN_P-1:0] r_fix_s;

    assign signed_s   = ~funct3[0];
    assign neg_a_s    = signed_s & a[XLEN_P-1];
    assign neg_b_s    = signed_s & b[XLEN_P-1];
    assign div_zero_s = (b == {XLEN_P{1'b0}});
    assign overflow_s = signed_s & (a == INT_MIN) & (b == {XLEN_P{1'b1}});

    cond_negate #(.W(XLEN_P)) u_neg_a (.neg(neg_a_s), .din(a),        .dout(a_mag_s));
    cond_negate #(.W(XLEN_P)) u_neg_b (.neg(neg_b_s), .din(b),        .dout(b_mag_s));
    cond_negate #(.W(XLEN_P)) u_neg_q (.neg(neg_q_r), .din(y_r),      .dout(q_fix_s));
    cond_negate #(.W(XLEN_P)) u_neg_r (.neg(neg_r_r), .din(rem_r),    .dout(r_fix_s));

    // Request sequencing FSM with registered outputs; flush beats start and core_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            rem_sel_r    <= 1'b0;
            neg_q_r      <= 1'b0;
            neg_r_r      <= 1'b0;
            out_valid_r  <= 1'b0;
            core_valid_r <= 1'b0;
            result_r     <= {XLEN_P{1'b0}};
            core_a_r     <= {XLEN_P{1'b0}};
            core_b_r     <= {XLEN_P{1'b0}};
            y_r          <= {XLEN_P{1'b0}};
            rem_r        <= {XLEN_P{1'b0}};
        end else if (flush_ex) begin
            state_r      <= IDLE;
            out_valid_r  <= 1'b0;
            core_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    if (start && funct3[2]) begin
                        rem_sel_r <= funct3[1];
                        neg_q_r   <= signed_s & (a[XLEN_P-1] ^ b[XLEN_P-1]);
                        neg_r_r   <= neg_a_s;
                        core_a_r  <= a_mag_s;
                        core_b_r  <= b_mag_s;
                        if (div_zero_s) begin
                            result_r    <= funct3[1] ? a : {XLEN_P{1'b1}};
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else if (overflow_s) begin
                            result_r    <= funct3[1] ? {XLEN_P{1'b0}} : INT_MIN;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            core_valid_r <= 1'b1;
                            state_r      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (core_done) begin
                        y_r          <= core_y;
                        rem_r        <= core_rem;
                        core_valid_r <= 1'b0;
                        state_r      <= FIX;
                    end
                end
                FIX: begin
                    result_r    <= rem_sel_r ? r_fix_s : q_fix_s;
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    out_valid_r  <= 1'b0;
                    core_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_r != IDLE);
    assign out_valid   = out_valid_r;
    assign result      = result_r;
    assign core_valid  = core_valid_r;
    assign core_a      = core_a_r;
    assign core_b      = core_b_r;
    assign core_funct3 = FUNCT3_DIVU;

endmodule
